write_back: RTL and testbench
=============================

WRITE_BACK -- requirements
Module: write_back

Interface
REQ-001 Parameter FLUSH_CYCLES, default 3 (legal 1..15), number of cycles flush stays high after a taken branch.
REQ-002 CLK  input  1  single clock; all state updates on posedge.
REQ-003 RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 rd_i  input  5  destination register from memory stage.
REQ-005 res_i  input  64  result to write (load data or ALU result).
REQ-006 wb_en_i  input  1  write-back enable for rd_i.
REQ-007 take_branch_i  input  1  memory stage reports branch taken.
REQ-008 branch_offset_i  input  64  branch offset, two's complement.
REQ-009 PC_i  input  64  PC of the instruction carried with the branch.
REQ-010 rs1_addr, rs2_addr  input  5 each  register read addresses.
REQ-011 rs1_data, rs2_data  output  64 each  combinational read data.
REQ-012 redirect  output  1  one-cycle fetch redirect pulse.
REQ-013 redirect_pc  output  64  redirect target, valid while redirect=1.
REQ-014 flush  output  1  squash request to all upstream stages.
REQ-015 retire_cnt  output  32  count of committed register writes.

Function
REQ-016 Block SHALL hold a 32 x 64-bit register file; reads of x0 SHALL return 0; writes to x0 SHALL be discarded.
REQ-017 On posedge, if wb_en_i=1, rd_i!=0 and state is IDLE, block SHALL write res_i to register rd_i (commit).
REQ-018 Writes sampled in REDIRECT or FLUSH state SHALL be discarded and not counted.
REQ-019 retire_cnt SHALL increment by 1 per commit; 32'hFFFFFFFF SHALL wrap to 0.
REQ-020 State machine SHALL have states IDLE, REDIRECT, FLUSH.
REQ-021 IDLE -> REDIRECT when take_branch_i=1 sampled on posedge; redirect_pc SHALL load PC_i + branch_offset_i, modulo 2^64.
REQ-022 A write sampled in the same cycle as take_branch_i in IDLE SHALL commit (branch instruction's own link write).
REQ-023 In REDIRECT: redirect=1, flush=1, exactly one cycle; next state FLUSH if FLUSH_CYCLES>1, else IDLE.
REQ-024 In FLUSH: flush=1, down-counter loaded with FLUSH_CYCLES-2 on entry; return to IDLE on the cycle after counter reaches 0; flush total high time SHALL equal FLUSH_CYCLES cycles.
REQ-025 take_branch_i sampled in REDIRECT or FLUSH SHALL be ignored (squashed instruction).
REQ-026 redirect and flush SHALL be registered outputs; redirect_pc SHALL hold its value until the next IDLE->REDIRECT transition.
REQ-027 Read ports SHALL be combinational from register file contents plus bypass per REQ-031/032.

Reset
REQ-028 RST_N=0 SHALL asynchronously clear all 32 registers, retire_cnt, redirect_pc, down-counter to 0, state to IDLE, redirect=0, flush=0.
REQ-029 Reset asserted mid-REDIRECT/FLUSH SHALL abandon the sequence; after release block SHALL start in IDLE with no pending redirect.
REQ-030 First posedge after RST_N rises SHALL be a normal IDLE cycle (commits allowed).

Configuration
REQ-031 Macro WB_BYPASS_EN defined: when a commit is pending this cycle (REQ-017 true) and rsN_addr==rd_i, rsN_data SHALL return res_i combinationally.
REQ-032 Macro WB_BYPASS_EN undefined: rsN_data SHALL return stored register value only; new value visible the cycle after commit.

Verification
REQ-033 Reset, then wb_en_i=1, rd_i=5, res_i=64'hDEAD_BEEF, rs1_addr=5 -> rs1_data=64'hDEAD_BEEF after posedge; retire_cnt=1.
REQ-034 wb_en_i=1, rd_i=0, res_i=64'h1234 -> rs1_addr=0 reads 0; retire_cnt unchanged.
REQ-035 take_branch_i=1, PC_i=64'h1000, branch_offset_i=-16 with FLUSH_CYCLES=3 -> redirect=1 one cycle, redirect_pc=64'h0FF0, flush high exactly 3 cycles; writes during flush discarded.
REQ-036 Second take_branch_i during flush -> no second redirect pulse, flush length unchanged.
REQ-037 With WB_BYPASS_EN: rd_i=7, res_i=64'hA5, rs2_addr=7 same cycle -> rs2_data=64'hA5 before posedge; without macro -> old value (0) until posedge.
REQ-038 Preload retire_cnt to 32'hFFFFFFFF via commits (force), commit once -> retire_cnt=0; RST_N pulsed low mid-FLUSH -> flush=0, redirect=0 immediately, state IDLE.

Source files
------------

// File: rtl/write_back.sv
// Write-back stage: 32x64 register file, retire counter and branch redirect/flush sequencer.
// Optional macro WB_BYPASS_EN forwards the committing result straight to the read ports.
module write_back #(
    parameter int unsigned FLUSH_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [4:0]  rd_i,
    input  logic [63:0] res_i,
    input  logic        wb_en_i,
    input  logic        take_branch_i,
    input  logic [63:0] branch_offset_i,
    input  logic [63:0] PC_i,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [63:0] rs1_data,
    output logic [63:0] rs2_data,
    output logic        redirect,
    output logic [63:0] redirect_pc,
    output logic        flush,
    output logic [31:0] retire_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    // REDIRECT contributes one flush cycle, FLUSH covers the remaining FLUSH_CYCLES-1
    localparam logic [3:0] CNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

    state_e       state_q, state_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         redirect_q, redirect_d;
    logic         flush_q, flush_d;
    logic [63:0]  rpc_q, rpc_d;
    logic [31:0]  retire_q, retire_d;
    logic [63:0]  regs_q [32];
    logic         commit_s;

    assign commit_s    = wb_en_i && (rd_i != 5'd0) && (state_q == ST_IDLE);
    assign redirect    = redirect_q;
    assign flush       = flush_q;
    assign redirect_pc = rpc_q;
    assign retire_cnt  = retire_q;

    // Next-state logic for the redirect/flush sequencer and retire counter
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rpc_d    = rpc_q;
        retire_d = retire_q;
        case (state_q)
            ST_IDLE: begin
                if (take_branch_i) begin
                    state_d = ST_REDIRECT;
                    rpc_d   = PC_i + branch_offset_i;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (FLUSH_CYCLES > 1) begin
                    state_d = ST_FLUSH;
                    cnt_d   = CNT_INIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (commit_s) begin
            retire_d = retire_q + 32'd1;
        end else begin
            retire_d = retire_q;
        end
        redirect_d = (state_d == ST_REDIRECT);
        flush_d    = (state_d != ST_IDLE);
    end

    // Control state registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            redirect_q <= 1'b0;
            flush_q    <= 1'b0;
            rpc_q      <= 64'd0;
            retire_q   <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            redirect_q <= redirect_d;
            flush_q    <= flush_d;
            rpc_q      <= rpc_d;
            retire_q   <= retire_d;
        end
    end

    // Register file storage; x0 is never written
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 64'd0;
            end
        end else if (commit_s) begin
            regs_q[rd_i] <= res_i;
        end
    end

    // Combinational read ports
    always_comb begin
        rs1_data = 64'd0;
        rs2_data = 64'd0;
        if (rs1_addr == 5'd0) begin
            rs1_data = 64'd0;
`ifdef WB_BYPASS_EN
        end else if (commit_s && (rs1_addr == rd_i)) begin
            rs1_data = res_i;
`endif
        end else begin
            rs1_data = regs_q[rs1_addr];
        end
        if (rs2_addr == 5'd0) begin
            rs2_data = 64'd0;
`ifdef WB_BYPASS_EN
        end else if (commit_s && (rs2_addr == rd_i)) begin
            rs2_data = res_i;
`endif
        end else begin
            rs2_data = regs_q[rs2_addr];
        end
    end

endmodule

// File: tb/tb_write_back.sv
// Self-checking bench for write_back: directed steps plus random traffic against a
// cycle-count model of the redirect/flush window and an array model of the register file.
module tb_write_back;

    localparam int FC = 3;

    logic        CLK;
    logic        RST_N;
    logic [4:0]  rd_i;
    logic [63:0] res_i;
    logic        wb_en_i;
    logic        take_branch_i;
    logic [63:0] branch_offset_i;
    logic [63:0] PC_i;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [63:0] rs1_data;
    logic [63:0] rs2_data;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        flush;
    logic [31:0] retire_cnt;

    write_back #(.FLUSH_CYCLES(FC)) dut (
        .CLK(CLK), .RST_N(RST_N), .rd_i(rd_i), .res_i(res_i), .wb_en_i(wb_en_i),
        .take_branch_i(take_branch_i), .branch_offset_i(branch_offset_i), .PC_i(PC_i),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .redirect(redirect), .redirect_pc(redirect_pc), .flush(flush), .retire_cnt(retire_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] m_regs [32];
    int          busy;      // flush cycles still to run, including the current one
    logic [31:0] m_ret;
    logic [63:0] m_pc;
    logic        m_redir;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
        busy    = 0;
        m_ret   = 32'd0;
        m_pc    = 64'd0;
        m_redir = 1'b0;
    endtask

    function automatic logic [63:0] exp_read(input logic [4:0] a);
        if (a == 5'd0) return 64'd0;
`ifdef WB_BYPASS_EN
        if (busy == 0 && wb_en_i && rd_i != 5'd0 && a == rd_i) return res_i;
`endif
        return m_regs[a];
    endfunction

    task automatic check_outputs();
        chk("redirect", {63'd0, redirect}, {63'd0, m_redir});
        chk("flush", {63'd0, flush}, {63'd0, (busy > 0)});
        chk("redirect_pc", redirect_pc, m_pc);
        chk("retire_cnt", {32'd0, retire_cnt}, {32'd0, m_ret});
    endtask

    // One clock: drive at negedge, check reads, update model at posedge, check outputs.
    task automatic step(input logic wb, input logic [4:0] rd, input logic [63:0] res,
                        input logic br, input logic [63:0] pc, input logic [63:0] off,
                        input logic [4:0] a1, input logic [4:0] a2);
        @(negedge CLK);
        wb_en_i = wb; rd_i = rd; res_i = res; take_branch_i = br;
        PC_i = pc; branch_offset_i = off; rs1_addr = a1; rs2_addr = a2;
        #1;
        chk("rs1_data", rs1_data, exp_read(a1));
        chk("rs2_data", rs2_data, exp_read(a2));
        @(posedge CLK);
        if (busy == 0) begin
            if (wb && rd != 5'd0) begin
                m_regs[rd] = res;
                m_ret      = m_ret + 32'd1;
            end
            if (br) begin
                busy    = FC;
                m_pc    = pc + off;
                m_redir = 1'b1;
            end else begin
                m_redir = 1'b0;
            end
        end else begin
            busy    = busy - 1;
            m_redir = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    initial begin
        logic [4:0] a1, a2, rd;
        RST_N = 1'b0;
        wb_en_i = 1'b0; rd_i = 5'd0; res_i = 64'd0; take_branch_i = 1'b0;
        PC_i = 64'd0; branch_offset_i = 64'd0; rs1_addr = 5'd5; rs2_addr = 5'd31;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check_outputs();
        chk("reset_rs1", rs1_data, 64'd0);
        chk("reset_rs2", rs2_data, 64'd0);
        @(negedge CLK);
        RST_N = 1'b1;

        // First cycle after reset commits; x7 read shows bypass or old value
        step(1'b1, 5'd7, 64'hA5, 1'b0, 64'd0, 64'd0, 5'd0, 5'd7);
        step(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0, 64'd0, 64'd0, 5'd5, 5'd7);
        step(1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd5, 5'd7);
        chk("commit_deadbeef", rs1_data, 64'hDEAD_BEEF);
        chk("retire_after_two", {32'd0, retire_cnt}, 64'd2);
        // x0 write discarded
        step(1'b1, 5'd0, 64'h1234, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0);
        chk("x0_read", rs1_data, 64'd0);
        chk("x0_not_counted", {32'd0, retire_cnt}, 64'd2);

        // Branch with its own link write, then writes and a second branch during flush
        step(1'b1, 5'd3, 64'h77, 1'b1, 64'h1000, -64'sd16, 5'd3, 5'd9);
        chk("redirect_pc_target", redirect_pc, 64'h0FF0);
        chk("redirect_pulse", {63'd0, redirect}, 64'd1);
        step(1'b1, 5'd9, 64'h99, 1'b1, 64'h2000, 64'h40, 5'd3, 5'd9);
        step(1'b1, 5'd9, 64'h98, 1'b0, 64'd0, 64'd0, 5'd3, 5'd9);
        chk("flush_last_cycle", {63'd0, flush}, 64'd1);
        step(1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd3, 5'd9);
        chk("flush_ended", {63'd0, flush}, 64'd0);
        chk("flush_write_dropped", rs2_data, 64'd0);
        chk("pc_held", redirect_pc, 64'h0FF0);

        // Counter wrap
        @(negedge CLK);
        force dut.retire_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_q;
        m_ret = 32'hFFFF_FFFF;
        #1;
        chk("retire_preload", {32'd0, retire_cnt}, 64'hFFFF_FFFF);
        step(1'b1, 5'd12, 64'h5, 1'b0, 64'd0, 64'd0, 5'd12, 5'd0);
        chk("retire_wrap", {32'd0, retire_cnt}, 64'd0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rd = 5'($urandom_range(0, 31));
            a1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            a2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            step(($urandom_range(0, 3) != 0), rd, {$urandom, $urandom},
                 ($urandom_range(0, 7) == 0), {$urandom, $urandom}, {$urandom, $urandom}, a1, a2);
        end

        // Reset in the middle of a flush sequence
        while (busy != 0) step(1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0);
        step(1'b0, 5'd0, 64'd0, 1'b1, 64'h400, 64'h20, 5'd0, 5'd0);
        step(1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd0, 5'd0);
        chk("in_flush_before_reset", {63'd0, flush}, 64'd1);
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge CLK);
        RST_N = 1'b1;
        step(1'b1, 5'd4, 64'h44, 1'b0, 64'd0, 64'd0, 5'd4, 5'd0);
        step(1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0, 5'd4, 5'd0);
        chk("post_reset_commit", rs1_data, 64'h44);
        chk("post_reset_no_flush", {63'd0, flush}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
